// File: rtl/ifetch_master_pkg.sv
// Shared definitions for the instruction-fetch bus master: bus encodings,
// FSM states and the overflow-free address range check.
package ifetch_master_pkg;

  localparam int ADDR_W     = 17;
  localparam int BUS_DATA_W = 17;
  // Three spare bits so addr + len and start + size can never wrap.
  localparam int CHK_W      = ADDR_W + 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_ADDR,
    ST_DRAIN,
    ST_WR
  } state_t;

  function automatic logic in_range(input logic [CHK_W-1:0] addr,
                                    input logic [CHK_W-1:0] len,
                                    input logic [CHK_W-1:0] start,
                                    input logic [CHK_W-1:0] size);
    return (addr >= start) && (addr + len <= start + size);
  endfunction

endpackage

// File: rtl/ifetch_master_if.sv
// Request/response port plus byte-wide memory bus of the fetch master.
// "master" is the view of ifetch_master, "slave" the view of core + memory.
interface ifetch_master_if #(
  parameter int ADDR_W      = 17,
  parameter int INSTR_BYTES = 2
) ();
  import ifetch_master_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDR_W-1:0]        req_addr;
  logic [7:0]               req_wdata;

  logic                     rsp_valid;
  logic [8*INSTR_BYTES-1:0] rsp_data;
  logic                     rsp_err;

  logic [ADDR_W-1:0]        HADDR;
  logic [1:0]               HTRANS;
  logic [BUS_DATA_W-1:0]    HWDATA;
  logic                     HWRITE;
  logic [BUS_DATA_W-1:0]    HRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, HRDATA,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           HADDR, HTRANS, HWDATA, HWRITE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, HRDATA,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           HADDR, HTRANS, HWDATA, HWRITE
  );

endinterface

// File: rtl/ifetch_master.sv
// Fetches INSTR_BYTES little-endian bytes or writes one byte through a
// byte-wide memory with one-cycle registered read latency.
module ifetch_master #(
  parameter int ADDR_W      = 17,
  parameter int INSTR_BYTES = 2,
  parameter int MEM_START   = 0,
  parameter int MEM_SIZE    = 256
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ifetch_master_if.master bus
);
  import ifetch_master_pkg::*;

  localparam int DATA_W = 8 * INSTR_BYTES;
  localparam int BEAT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INSTR_BYTES - 1);
  localparam logic [CHK_W-1:0]  START_C   = CHK_W'(MEM_START);
  localparam logic [CHK_W-1:0]  SIZE_C    = CHK_W'(MEM_SIZE);

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [ADDR_W-1:0]     haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [BUS_DATA_W-1:0] hwdata_q, hwdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  accept;
  logic                  legal;
  logic [DATA_W+7:0]     shift_in;
  logic [DATA_W-1:0]     captured;

  assign accept   = bus.req_valid && ready_q;
  assign legal    = in_range(CHK_W'(bus.req_addr),
                             bus.req_write ? CHK_W'(1) : CHK_W'(INSTR_BYTES),
                             START_C, SIZE_C);
  // New byte enters at the top; after INSTR_BYTES shifts byte A sits in [7:0].
  assign shift_in = {bus.HRDATA[7:0], shift_q};
  assign captured = shift_in[DATA_W+7:8];

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d     = state_q;
    beat_d      = beat_q;
    shift_d     = shift_q;
    haddr_d     = haddr_q;
    htrans_d    = HTRANS_IDLE;
    hwrite_d    = 1'b0;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else if (bus.req_write) begin
            state_d  = ST_WR;
            haddr_d  = bus.req_addr;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
            hwdata_d = {9'b0, bus.req_wdata};
          end else begin
            state_d  = ST_ADDR;
            haddr_d  = bus.req_addr;
            htrans_d = HTRANS_NONSEQ;
            beat_d   = '0;
          end
        end
      end
      ST_ERR: state_d = ST_IDLE;
      ST_ADDR: begin
        // Read data trails its address phase by one cycle.
        if (beat_q != '0) shift_d = captured;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DRAIN;
        end else begin
          haddr_d  = haddr_q + 1'b1;
          htrans_d = HTRANS_SEQ;
          beat_d   = beat_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d     = ST_IDLE;
        shift_d     = captured;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = captured;
      end
      ST_WR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      beat_q      <= '0;
      shift_q     <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      shift_q     <= shift_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ifetch_master.sv
// Directed bench for ifetch_master: a 256-byte registered-read memory model,
// plus a second instance spanning the full 17-bit space for the top boundary.
module tb_ifetch_master;
  import ifetch_master_pkg::*;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ifetch_master_if #(.ADDR_W(17), .INSTR_BYTES(2)) bus ();
  ifetch_master_if #(.ADDR_W(17), .INSTR_BYTES(2)) bus_big ();

  ifetch_master #(.ADDR_W(17), .INSTR_BYTES(2), .MEM_START(0), .MEM_SIZE(256)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus.master)
  );

  ifetch_master #(.ADDR_W(17), .INSTR_BYTES(2), .MEM_START(0), .MEM_SIZE(131072)) dut_big (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_big.master)
  );

  always #5 HCLK = ~HCLK;

  // Slave writes on HWRITE alone and reads regardless of HTRANS.
  logic [7:0] mem [256];
  always @(posedge HCLK) begin
    if (bus.HWRITE) mem[bus.HADDR[7:0]] <= bus.HWDATA[7:0];
    bus.HRDATA <= {9'b0, mem[bus.HADDR[7:0]]};
  end

  always @(posedge HCLK) bus_big.HRDATA <= {9'b0, bus_big.HADDR[7:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge HCLK)
    check("hwrite_without_htrans", 32'(bus.HWRITE && bus.HTRANS == HTRANS_IDLE), 0);

  task automatic present(input logic wr, input logic [16:0] a, input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // All sequence tasks are entered just after a falling edge with the DUT idle.
  task automatic do_write(input logic [16:0] a, input logic [7:0] d);
    check("wr_ready", bus.req_ready, 1);
    present(1'b1, a, d);
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    check("wr_haddr", bus.HADDR, a);
    check("wr_hwrite", bus.HWRITE, 1);
    check("wr_htrans", bus.HTRANS, HTRANS_NONSEQ);
    check("wr_hwdata", bus.HWDATA, {9'b0, d});
    check("wr_rsp_early", bus.rsp_valid, 0);
    @(negedge HCLK);
    check("wr_hwrite_off", bus.HWRITE, 0);
    check("wr_htrans_off", bus.HTRANS, HTRANS_IDLE);
    check("wr_hwdata_hold", bus.HWDATA, {9'b0, d});
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_err", bus.rsp_err, 0);
    check("wr_rsp_data", bus.rsp_data, 0);
    check("wr_ready_back", bus.req_ready, 1);
    @(negedge HCLK);
    check("wr_rsp_pulse", bus.rsp_valid, 0);
  endtask

  task automatic do_fetch(input logic [16:0] a, input logic [15:0] exp);
    check("f_ready", bus.req_ready, 1);
    present(1'b0, a, 8'h00);
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    check("f_htrans0", bus.HTRANS, HTRANS_NONSEQ);
    check("f_haddr0", bus.HADDR, a);
    check("f_busy", bus.req_ready, 0);
    @(negedge HCLK);
    check("f_htrans1", bus.HTRANS, HTRANS_SEQ);
    check("f_haddr1", bus.HADDR, 17'(a + 17'd1));
    @(negedge HCLK);
    check("f_htrans_idle", bus.HTRANS, HTRANS_IDLE);
    check("f_haddr_hold", bus.HADDR, 17'(a + 17'd1));
    check("f_rsp_early", bus.rsp_valid, 0);
    @(negedge HCLK);
    check("f_rsp_valid", bus.rsp_valid, 1);
    check("f_rsp_data", bus.rsp_data, exp);
    check("f_rsp_err", bus.rsp_err, 0);
    check("f_ready_back", bus.req_ready, 1);
    @(negedge HCLK);
    check("f_rsp_pulse", bus.rsp_valid, 0);
    check("f_rsp_data_hold", bus.rsp_data, exp);
  endtask

  task automatic do_reject(input logic wr, input logic [16:0] a);
    check("rj_ready", bus.req_ready, 1);
    present(wr, a, 8'h77);
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    check("rj_rsp_valid", bus.rsp_valid, 1);
    check("rj_rsp_err", bus.rsp_err, 1);
    check("rj_rsp_data", bus.rsp_data, 0);
    check("rj_htrans", bus.HTRANS, HTRANS_IDLE);
    check("rj_hwrite", bus.HWRITE, 0);
    check("rj_busy", bus.req_ready, 0);
    @(negedge HCLK);
    check("rj_rsp_pulse", bus.rsp_valid, 0);
    check("rj_htrans_after", bus.HTRANS, HTRANS_IDLE);
    check("rj_err_hold", bus.rsp_err, 1);
    check("rj_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within 200000 time units");
    $fatal(1);
  end

  initial begin
    int pulses;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus_big.req_valid = 1'b0;
    bus_big.req_write = 1'b0;
    bus_big.req_addr  = '0;
    bus_big.req_wdata = '0;

    repeat (3) @(negedge HCLK);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_htrans", bus.HTRANS, HTRANS_IDLE);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("ready_after_release", bus.req_ready, 1);

    do_write(17'h010, 8'hA5);

    do_write(17'h010, 8'h34);
    do_write(17'h011, 8'h12);
    do_fetch(17'h010, 16'h1234);

    do_reject(1'b0, 17'h0FF);
    do_reject(1'b1, 17'h100);

    do_write(17'h0FE, 8'hC3);
    do_write(17'h0FF, 8'h5A);
    do_fetch(17'h0FE, 16'h5AC3);

    // Back-to-back fetches with req_valid held high throughout.
    do_write(17'h000, 8'h11);
    do_write(17'h001, 8'h22);
    do_write(17'h002, 8'h33);
    do_write(17'h003, 8'h44);
    present(1'b0, 17'h000, 8'h00);
    @(negedge HCLK);
    present(1'b0, 17'h002, 8'h00);
    check("b2b_haddr0", bus.HADDR, 17'h000);
    check("b2b_htrans0", bus.HTRANS, HTRANS_NONSEQ);
    @(negedge HCLK);
    check("b2b_haddr1", bus.HADDR, 17'h001);
    check("b2b_htrans1", bus.HTRANS, HTRANS_SEQ);
    check("b2b_busy", bus.req_ready, 0);
    @(negedge HCLK);
    check("b2b_drain_idle", bus.HTRANS, HTRANS_IDLE);
    check("b2b_drain_rsp", bus.rsp_valid, 0);
    @(negedge HCLK);
    check("b2b_rsp1_valid", bus.rsp_valid, 1);
    check("b2b_rsp1_data", bus.rsp_data, 16'h2211);
    check("b2b_rsp1_ready", bus.req_ready, 1);
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    check("b2b_rsp1_pulse", bus.rsp_valid, 0);
    check("b2b_haddr2", bus.HADDR, 17'h002);
    check("b2b_htrans2", bus.HTRANS, HTRANS_NONSEQ);
    @(negedge HCLK);
    check("b2b_haddr3", bus.HADDR, 17'h003);
    check("b2b_htrans3", bus.HTRANS, HTRANS_SEQ);
    @(negedge HCLK);
    check("b2b_drain2_idle", bus.HTRANS, HTRANS_IDLE);
    @(negedge HCLK);
    check("b2b_rsp2_valid", bus.rsp_valid, 1);
    check("b2b_rsp2_data", bus.rsp_data, 16'h4433);
    check("b2b_rsp2_err", bus.rsp_err, 0);
    @(negedge HCLK);
    check("b2b_rsp2_pulse", bus.rsp_valid, 0);

    // Reset during the SEQ beat drops the fetch without a response.
    present(1'b0, 17'h010, 8'h00);
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    check("mid_htrans0", bus.HTRANS, HTRANS_NONSEQ);
    @(negedge HCLK);
    check("mid_htrans1", bus.HTRANS, HTRANS_SEQ);
    HRESET = 1'b1;
    #1;
    check("mid_rst_htrans", bus.HTRANS, HTRANS_IDLE);
    check("mid_rst_haddr", bus.HADDR, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_data", bus.rsp_data, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (bus.rsp_valid) pulses++;
    end
    check("mid_no_response", pulses, 0);
    do_write(17'h010, 8'h34);
    do_write(17'h011, 8'h12);
    do_fetch(17'h010, 16'h1234);

    // Full 17-bit memory: the last byte cannot start a 2-byte fetch.
    check("big_ready", bus_big.req_ready, 1);
    bus_big.req_valid = 1'b1;
    bus_big.req_write = 1'b0;
    bus_big.req_addr  = 17'h1FFFF;
    @(negedge HCLK);
    bus_big.req_valid = 1'b0;
    check("big_rsp_valid", bus_big.rsp_valid, 1);
    check("big_rsp_err", bus_big.rsp_err, 1);
    check("big_rsp_data", bus_big.rsp_data, 0);
    check("big_htrans", bus_big.HTRANS, HTRANS_IDLE);
    @(negedge HCLK);
    check("big_htrans_after", bus_big.HTRANS, HTRANS_IDLE);
    check("big_ready_back", bus_big.req_ready, 1);
    bus_big.req_valid = 1'b1;
    bus_big.req_addr  = 17'h1FFFE;
    @(negedge HCLK);
    bus_big.req_valid = 1'b0;
    check("big_top_haddr0", bus_big.HADDR, 17'h1FFFE);
    check("big_top_htrans0", bus_big.HTRANS, HTRANS_NONSEQ);
    @(negedge HCLK);
    check("big_top_haddr1", bus_big.HADDR, 17'h1FFFF);
    check("big_top_htrans1", bus_big.HTRANS, HTRANS_SEQ);
    @(negedge HCLK);
    check("big_top_idle", bus_big.HTRANS, HTRANS_IDLE);
    @(negedge HCLK);
    check("big_top_rsp_valid", bus_big.rsp_valid, 1);
    check("big_top_rsp_err", bus_big.rsp_err, 0);
    check("big_top_rsp_data", bus_big.rsp_data, 16'hFFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_master.md
Name: ifetch_master

Overview:
- Bus initiator that drives the byte-wide instruction memory slave (HADDR/HTRANS/HWRITE/HWDATA out, HRDATA in).
- Serves two request types from a valid/ready port:
  - Instruction fetch: reads INSTR_BYTES consecutive bytes and assembles them little-endian.
  - Single-byte write: used by the program loader to fill instruction memory.
- Sits between the core/loader and the instruction memory.
- Accounts for the slave's one-cycle registered read latency and its lack of HTRANS gating.

Parameters:
- ADDR_W, 17, bus address width.
- INSTR_BYTES, 2, bytes per fetch; legal range 1..4.
- MEM_START, 0, first valid byte address of the target memory.
- MEM_SIZE, 256, number of valid bytes in the target memory.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_write  in  1  1 = byte write, 0 = fetch.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_data  out  8*INSTR_BYTES  fetched instruction, byte at req_addr in [7:0]; 0 for writes and errors.
- rsp_err  out  1  request out of range; qualified by rsp_valid.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWDATA  out  17  write data, {9'b0, byte}.
- HWRITE  out  1  write strobe.
- HRDATA  in  17  read data; only [7:0] is used.

Behaviour:
- All outputs are registered.
- Reset values:
  - HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE.
- req_ready rises on the first HCLK edge after reset release.
- req_ready is 1 exactly when the FSM is in IDLE.
- States and transitions:
  - IDLE: accept a request.
  - ERR: one-cycle response for an out-of-range request.
  - ADDR: issues the fetch address phases.
  - DRAIN: captures the last read byte.
  - WR: single write phase.
  - IDLE→ERR, ADDR or WR on acceptance.
  - ERR→IDLE.
  - ADDR→DRAIN after INSTR_BYTES address phases.
  - DRAIN→IDLE.
  - WR→IDLE.
- Range check, evaluated at acceptance in ADDR_W+3 bits so there is no overflow or wrap:
  - Fetch is legal iff req_addr >= MEM_START and req_addr+INSTR_BYTES <= MEM_START+MEM_SIZE.
  - Write is legal iff req_addr+1 <= MEM_START+MEM_SIZE and req_addr >= MEM_START.
  - Illegal request: no bus activity (HTRANS stays 00, HWRITE stays 0). rsp_valid=1, rsp_err=1, rsp_data=0 in the cycle after the acceptance edge E0.
- Fetch timing, accepted at edge E0:
  - Cycles after E0 through E0+INSTR_BYTES-1: HADDR = A, A+1, … on successive cycles.
  - HTRANS = NONSEQ on the first beat, SEQ on the rest.
  - The byte for address A+k is sampled from HRDATA[7:0] at edge E0+k+2.
  - After the last address beat: HTRANS=00. HADDR holds its last value.
  - rsp_valid is registered at E0+INSTR_BYTES+1, so it is high in the following cycle.
  - The FSM is back in IDLE in the rsp_valid cycle, so back-to-back requests are accepted in that cycle.
- Write timing, accepted at E0:
  - Cycle after E0: HADDR=A, HWRITE=1, HTRANS=10, HWDATA={9'b0, wdata}.
  - Next cycle: HWRITE=0, HTRANS=00, rsp_valid=1, rsp_err=0, rsp_data=0.
- Invariant: HWRITE=0 whenever HTRANS=00. The slave writes on HWRITE alone, so this must always hold.
- HWDATA holds its last value when not writing.
- rsp_valid is a single-cycle pulse. rsp_data and rsp_err hold until the next response.
- Request inputs are ignored while req_ready=0.
- Reset mid-operation: all outputs return to reset values immediately and the in-flight transaction is dropped with no response. Captured bytes are cleared.

Decomposition:
- Shared package contents:
  - HTRANS encodings (HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ).
  - ADDR_W=17 and BUS_DATA_W=17.
  - FSM state enum.
  - Range-check function in_range(addr, len, start, size).
- No sub-module. Beat counter, byte shift/assembly register and FSM are all kept in ifetch_master.

Test Plan:
- Write 0x10=0xA5 after reset:
  - One cycle with HADDR=0x10, HWRITE=1, HTRANS=10, HWDATA=0x0A5.
  - Next cycle rsp_valid=1, rsp_err=0, HWRITE=0.
- Preload 0x10=0x34 and 0x11=0x12, then fetch 0x10:
  - HTRANS goes 10 then 11, HADDR 0x10 then 0x11.
  - rsp_valid in the cycle after edge E0+3 with rsp_data=0x1234, rsp_err=0.
- Fetch 0xFF (MEM_SIZE=256, INSTR_BYTES=2):
  - HTRANS stays 00.
  - rsp_valid in the cycle after E0, rsp_err=1, rsp_data=0.
- req_valid held high with fetch 0x00, then 0x02 presented when the first is accepted:
  - Second request accepted during the first rsp_valid cycle.
  - HADDR sequence is 0,1,2,3.
  - Two responses with correct data and no lost cycles beyond the drain.
- HRESET asserted during the SEQ beat of a fetch:
  - HTRANS=00, HADDR=0, rsp_valid=0 immediately, and no response follows.
  - After release, fetch 0x10 returns 0x1234 once memory is reloaded.
- MEM_SIZE=2^17, fetch 0x1FFFF:
  - rsp_err=1 with no bus activity; the address does not wrap to 0.
